// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, variable-latency memory between the instruction
//   fetch port and the data port. DATA has fixed priority over FETCH, and only
//   one bus transaction is outstanding at a time. Each completion is reported
//   as a one-cycle valid pulse to the requester that owns the transaction.
//   A fetch can be dropped on a PC redirect (if_flush).
//
//   Optional feature macro: ARB_STARVE_EN
//     When it is defined, FETCH is forced through after STARVE_LIMIT
//     consecutive DATA grants made while a fetch was pending.
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   if_req/if_addr/if_flush      fetch request, PC, redirect
//   if_valid/if_rdata            fetch completion pulse and instruction
//   dm_req/dm_we/dm_addr/dm_wdata  data request (load/store)
//   dm_valid/dm_rdata            data completion pulse and load data
//   mem_req/mem_we/mem_addr/mem_wdata  bus request side
//   mem_ready                    bus accepts when mem_req & mem_ready
//   mem_rvalid/mem_rdata         bus completion and read data
//   bus_err                      one-cycle pulse on a timeout completion
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t     state, state_nxt;
    logic       owner_fetch;   // 1 = FETCH owns the current transaction
    logic       discard;       // fetch flushed while outstanding
    logic [7:0] tmo_cnt;
    logic       fetch_ok;
    logic       grant_data, grant_fetch;
    logic       tmo_hit;
    logic       done;
    logic       starve_force;

    assign fetch_ok = if_req & ~if_flush;

    // tmo_cnt is 0 in the first RESP cycle. Deciding at cnt+2 >= TIMEOUT puts
    // the registered error pulse exactly TIMEOUT cycles after the accepting
    // cycle (earliest possible for TIMEOUT of 1 or 2).
    assign tmo_hit = (state == RESP) && !mem_rvalid && (TMO != 8'd0) &&
                     (({1'b0, tmo_cnt} + 9'd2) >= {1'b0, TMO});
    assign done    = (state == RESP) && (mem_rvalid || tmo_hit);

`ifdef ARB_STARVE_EN
    logic [7:0] starve_cnt;

    assign starve_force = (starve_cnt == 8'(STARVE_LIMIT)) && fetch_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_data) begin
            starve_cnt <= fetch_ok ? starve_cnt + 8'd1 : 8'd0;
        end else if (grant_fetch) begin
            starve_cnt <= '0;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        mem_req     = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req && !starve_force) grant_data  = 1'b1;
                else if (fetch_ok)           grant_fetch = 1'b1;
                if (grant_data || grant_fetch) state_nxt = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ready) state_nxt = RESP;
            end
            RESP: begin
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_fetch <= 1'b0;
            discard     <= 1'b0;
            tmo_cnt     <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_valid    <= 1'b0;
            if_rdata    <= '0;
            dm_valid    <= 1'b0;
            dm_rdata    <= '0;
            bus_err     <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            bus_err  <= 1'b0;

            if (grant_data) begin
                owner_fetch <= 1'b0;
                mem_we      <= dm_we;
                mem_addr    <= dm_addr;
                mem_wdata   <= dm_wdata;
            end else if (grant_fetch) begin
                owner_fetch <= 1'b1;
                mem_we      <= 1'b0;
                mem_addr    <= if_addr;
                mem_wdata   <= '0;
            end

            if (state == REQ)       tmo_cnt <= '0;
            else if (state == RESP) tmo_cnt <= tmo_cnt + 8'd1;

            if ((state == REQ || state == RESP) && owner_fetch && if_flush)
                discard <= 1'b1;

            // A flush in the completing cycle also suppresses the fetch pulse.
            if (done) begin
                discard <= 1'b0;
                bus_err <= tmo_hit;
                if (owner_fetch) begin
                    if (!discard && !if_flush) begin
                        if_valid <= 1'b1;
                        if_rdata <= mem_rvalid ? mem_rdata : '0;
                    end
                end else begin
                    dm_valid <= 1'b1;
                    dm_rdata <= mem_rvalid ? mem_rdata : '0;
                end
            end
        end
    end

endmodule
